asm_volume_param: RTL and testbench
===================================

ASM_VOLUME_PARAM -- requirements
Module: asm_volume_param

Interface
REQ-001 SHALL have parameter MAX_VOL, default 10, upper volume limit (1..99).
REQ-002 SHALL have parameter STEP, default 1, increment/decrement per accepted press (1..MAX_VOL).
REQ-003 SHALL have parameter VOL_RESET, default 0, volume loaded at reset (0..MAX_VOL).
REQ-004 SHALL have parameter RPT_DELAY, default 25_000_000, cycles a button is held before auto-repeat starts.
REQ-005 SHALL have parameter RPT_PERIOD, default 5_000_000, cycles between auto-repeat steps.
REQ-006 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port aumenta  input  1  level "volume up" button, synchronous to clk.
REQ-009 SHALL have port diminui  input  1  level "volume down" button, synchronous to clk.
REQ-010 SHALL have port mute  input  1  level mute toggle button, synchronous to clk.
REQ-011 SHALL have port volume  output  7  effective binary volume (0 while muted).
REQ-012 SHALL have port volume1  output  4  BCD tens digit of volume.
REQ-013 SHALL have port volume0  output  4  BCD units digit of volume.
REQ-014 SHALL have port mudo  output  1  high while muted.
REQ-015 SHALL have port mudou_volume  output  1  one-cycle pulse when volume changes.

Function
REQ-016 SHALL register each button and act only on its rising edge (low in previous cycle, high now); a held level counts as one press.
REQ-017 SHALL hold internal stored volume nivel (7 bits), separate from mute flag.
REQ-018 SHALL implement states ATIVO and MUDO; reset enters ATIVO.
REQ-019 ATIVO, aumenta edge: nivel = min(nivel+STEP, MAX_VOL); diminui edge: nivel = max(nivel-STEP, 0), computed without underflow.
REQ-020 ATIVO, mute edge: go to MUDO, nivel retained, volume becomes 0.
REQ-021 MUDO, mute edge or aumenta edge: return to ATIVO, volume = retained nivel, no step applied; diminui edge ignored.
REQ-022 Same-cycle priority: mute edge beats aumenta/diminui; simultaneous aumenta and diminui edges ignored.
REQ-023 At limits (nivel at MAX_VOL on up, 0 on down) nivel unchanged and no pulse.
REQ-024 mudou_volume SHALL pulse high exactly one cycle after the edge cycle iff volume output value changes; entering/leaving MUDO with nivel 0 gives no pulse.
REQ-025 volume, volume1, volume0, mudo SHALL be registered, updating in the same cycle as mudou_volume (latency 1 cycle from edge).
REQ-026 volume1 = volume/10, volume0 = volume%10, each 0..9.

Reset
REQ-027 reset high SHALL immediately force nivel=VOL_RESET, state ATIVO, mudo=0, volume=VOL_RESET with matching BCD, mudou_volume=0, edge registers=0, repeat counter=0.
REQ-028 Reset asserted mid-press SHALL discard the press; button still high at release of reset SHALL NOT be seen as an edge until it goes low then high.

Configuration
REQ-029 With VOLUME_AUTOREPEAT_EN defined: in ATIVO, aumenta or diminui held alone for RPT_DELAY cycles after its edge generates one step, then one more step every RPT_PERIOD cycles while held; each step obeys REQ-019/023/024; release, second button, mute or reset clears counter.
REQ-030 Without VOLUME_AUTOREPEAT_EN: no repeat counter is built; holding a button produces exactly one step.

Verification
REQ-031 Reset with VOL_RESET=0, diminui press -> volume 0, volume1=0 volume0=0, no mudou_volume pulse.
REQ-032 From 0, 11 aumenta presses (MAX_VOL=10, STEP=1) -> 10 pulses, final volume1=1 volume0=0; 11th press no pulse.
REQ-033 Volume 7, mute press -> mudo=1, volume 0, one pulse; aumenta press -> mudo=0, volume 7, one pulse; diminui while muted -> no change.
REQ-034 Volume 5, aumenta and diminui rising same cycle -> volume 5, no pulse; mute+aumenta same cycle -> MUDO, volume 0.
REQ-035 VOLUME_AUTOREPEAT_EN, RPT_DELAY=8, RPT_PERIOD=4, volume 0, aumenta held 20 cycles -> steps at edge, +8, +12, +16, +20 cycles: volume 5.
REQ-036 reset pulse mid-hold of aumenta at volume 9 -> volume VOL_RESET immediately, no step until aumenta released and pressed again.

Source files
------------

// File: rtl/asm_volume_param.sv
// asm_volume_param: button-driven volume control with mute, BCD outputs and change pulse.
// Optional VOLUME_AUTOREPEAT_EN adds hold-to-repeat stepping on the up/down buttons.
module asm_volume_param #(
  parameter int MAX_VOL    = 10,
  parameter int STEP       = 1,
  parameter int VOL_RESET  = 0,
  parameter int RPT_DELAY  = 25_000_000,
  parameter int RPT_PERIOD = 5_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       aumenta,
  input  logic       diminui,
  input  logic       mute,
  output logic [6:0] volume,
  output logic [3:0] volume1,
  output logic [3:0] volume0,
  output logic       mudo,
  output logic       mudou_volume
);
  typedef enum logic {ATIVO, MUDO} state_t;
  state_t state, state_n;
  logic [6:0] nivel, nivel_n, vol_n;
  logic [2:0] btn, prev, arm, rise;
  logic up, dn, rep;
  assign btn  = {mute, diminui, aumenta};
  // arm stays low after reset until a button is seen released, so a held press is never replayed
  assign rise = btn & ~prev & arm;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      prev <= '0;
      arm  <= '0;
    end else begin
      prev <= btn;
      arm  <= arm | ~btn;
    end
`ifdef VOLUME_AUTOREPEAT_EN
  logic [31:0] cnt;
  logic phase, held, start, run;
  assign held  = (aumenta ^ diminui) & ~mute & (state == ATIVO);
  assign start = held & (rise[0] | rise[1]);
  assign run   = held & (cnt != '0);
  assign rep   = run & (cnt == (phase ? 32'(RPT_PERIOD) : 32'(RPT_DELAY)));
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (start | rep) begin
      cnt   <= 32'd1;
      phase <= rep;
    end else begin
      cnt   <= run ? cnt + 32'd1 : '0;
      phase <= run & phase;
    end
`else
  assign rep = 1'b0 & (RPT_DELAY > 0) & (RPT_PERIOD > 0);
`endif
  assign up = (rise[0] & ~rise[1]) | (rep & aumenta);
  assign dn = (rise[1] & ~rise[0]) | (rep & diminui);
  always_comb begin
    state_n = state;
    nivel_n = nivel;
    if (state == ATIVO) begin
      if (rise[2])
        state_n = MUDO;
      else if (up)
        nivel_n = (8'(nivel) + 8'(STEP) > 8'(MAX_VOL)) ? 7'(MAX_VOL) : nivel + 7'(STEP);
      else if (dn)
        nivel_n = (nivel < 7'(STEP)) ? 7'd0 : nivel - 7'(STEP);
    end else if (rise[2] | rise[0])
      state_n = ATIVO;
    vol_n = (state_n == MUDO) ? 7'd0 : nivel_n;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state        <= ATIVO;
      nivel        <= 7'(VOL_RESET);
      volume       <= 7'(VOL_RESET);
      volume1      <= 4'(VOL_RESET / 10);
      volume0      <= 4'(VOL_RESET % 10);
      mudo         <= 1'b0;
      mudou_volume <= 1'b0;
    end else begin
      state        <= state_n;
      nivel        <= nivel_n;
      volume       <= vol_n;
      volume1      <= 4'(vol_n / 7'd10);
      volume0      <= 4'(vol_n % 7'd10);
      mudo         <= state_n == MUDO;
      mudou_volume <= vol_n != volume;
    end
endmodule

// File: tb/tb_asm_volume_param.sv
// tb_asm_volume_param: scoreboard bench for asm_volume_param (honours VOLUME_AUTOREPEAT_EN).
module tb_asm_volume_param;
  localparam int MAXV = 10, STP = 1, VR = 0, RD = 8, RP = 4;
  logic clk = 0, reset = 1, aumenta = 0, diminui = 0, mute = 0;
  logic [6:0] volume;
  logic [3:0] volume1, volume0;
  logic mudo, mudou_volume;
  typedef struct {int vol; int mut; int pul;} exp_t;
  exp_t q[$];
  int total = 0, bad = 0, npulse = 0;
  int m_lvl, m_mut, m_vol, since;
  bit pa, pd, pm, aa, ad, am;

  asm_volume_param #(.MAX_VOL(MAXV), .STEP(STP), .VOL_RESET(VR), .RPT_DELAY(RD), .RPT_PERIOD(RP)) dut (
    .clk(clk), .reset(reset), .aumenta(aumenta), .diminui(diminui), .mute(mute),
    .volume(volume), .volume1(volume1), .volume0(volume0), .mudo(mudo), .mudou_volume(mudou_volume)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic mreset();
    m_lvl = VR; m_mut = 0; m_vol = VR; since = -1;
    pa = 0; pd = 0; pm = 0; aa = 0; ad = 0; am = 0;
  endtask

  task automatic cyc(input bit a, input bit d, input bit m);
    exp_t e;
    bit ra, rd, rm, alone, rep;
    @(negedge clk);
    aumenta = a; diminui = d; mute = m;
    ra = a && !pa && aa;
    rd = d && !pd && ad;
    rm = m && !pm && am;
    pa = a; pd = d; pm = m;
    aa = aa || !a; ad = ad || !d; am = am || !m;
    alone = (a != d) && !m && (m_mut == 0);
    rep = 0;
    if (alone && (ra || rd)) since = 0;
    else if (alone && since >= 0) begin
      since++;
      rep = (since == RD) || (since > RD && (since - RD) % RP == 0);
    end else since = -1;
`ifndef VOLUME_AUTOREPEAT_EN
    rep = 0;
`endif
    if (rm) m_mut = 1 - m_mut;
    else if (m_mut != 0) begin
      if (ra) m_mut = 0;
    end else if ((ra && !rd) || (rep && a)) m_lvl = (m_lvl + STP > MAXV) ? MAXV : m_lvl + STP;
    else if ((rd && !ra) || (rep && d)) m_lvl = (m_lvl < STP) ? 0 : m_lvl - STP;
    e.vol = (m_mut != 0) ? 0 : m_lvl;
    e.mut = m_mut;
    e.pul = (e.vol != m_vol) ? 1 : 0;
    m_vol = e.vol;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("volume", 32'(volume), e.vol);
    chk("volume1", 32'(volume1), e.vol / 10);
    chk("volume0", 32'(volume0), e.vol % 10);
    chk("mudo", 32'(mudo), e.mut);
    chk("pulse", 32'(mudou_volume), e.pul);
    if (mudou_volume) npulse++;
  endtask

  task automatic press(input bit a, input bit d, input bit m);
    cyc(a, d, m);
    cyc(0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    mreset();
    #1;
    chk("rst_vol", 32'(volume), VR);
    chk("rst_v0", 32'(volume0), VR % 10);
    chk("rst_mudo", 32'(mudo), 0);
    chk("rst_pulse", 32'(mudou_volume), 0);
    @(posedge clk);
    #1 reset = 0;
  endtask

  initial begin
    mreset();
    repeat (2) @(posedge clk);
    #1;
    chk("init_vol", 32'(volume), VR);
    chk("init_v1", 32'(volume1), VR / 10);
    chk("init_v0", 32'(volume0), VR % 10);
    chk("init_mudo", 32'(mudo), 0);
    chk("init_pulse", 32'(mudou_volume), 0);
    reset = 0;
    cyc(0, 0, 0);
    npulse = 0;
    press(0, 1, 0);
    chk("dn_at_0_pulses", npulse, 0);
    npulse = 0;
    repeat (11) press(1, 0, 0);
    chk("up11_pulses", npulse, 10);
    chk("up11_v1", 32'(volume1), 1);
    chk("up11_v0", 32'(volume0), 0);
    repeat (3) press(0, 1, 0);
    chk("at7", 32'(volume), 7);
    npulse = 0;
    press(0, 0, 1);
    chk("mute_mudo", 32'(mudo), 1);
    chk("mute_vol", 32'(volume), 0);
    press(1, 0, 0);
    chk("unmute_vol", 32'(volume), 7);
    chk("mute_pulses", npulse, 2);
    press(0, 0, 1);
    press(0, 1, 0);
    press(0, 0, 1);
    chk("dn_muted_vol", 32'(volume), 7);
    repeat (2) press(0, 1, 0);
    npulse = 0;
    press(1, 1, 0);
    chk("both_vol", 32'(volume), 5);
    chk("both_pulses", npulse, 0);
    press(1, 0, 1);
    chk("mute_up_mudo", 32'(mudo), 1);
    chk("mute_up_vol", 32'(volume), 0);
    press(0, 0, 1);
    repeat (4) press(1, 0, 0);
    chk("at9", 32'(volume), 9);
    repeat (3) cyc(1, 0, 0);
    do_reset();
    repeat (4) cyc(1, 0, 0);
    chk("held_after_rst", 32'(volume), VR);
    cyc(0, 0, 0);
    press(1, 0, 0);
    chk("repress_after_rst", 32'(volume), VR + STP);
    do_reset();
    cyc(0, 0, 0);
    npulse = 0;
    press(0, 0, 1);
    press(0, 0, 1);
    chk("mute_at_0_pulses", npulse, 0);
    repeat (21) cyc(1, 0, 0);
`ifdef VOLUME_AUTOREPEAT_EN
    chk("hold_vol", 32'(volume), 5);
`else
    chk("hold_vol", 32'(volume), 1);
`endif
    cyc(0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
